// File: rtl/ssd_disparity_scheduler_if.sv
// Bundle between the disparity scheduler, the request front end, the SSD datapath and the
// depth-map writer. The scheduler takes the slave side; the environment drives the master side.
interface ssd_disparity_scheduler_if #(
    parameter int MAX_DISP  = 16,
    parameter int SSD_WIDTH = 24,
    parameter int X_WIDTH   = 10
);
    localparam int DISP_W = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;

    // Request handshake: a request transfers on a rising clk_in edge where req_valid_in
    // and req_ready_out are both 1. The requester holds req_valid_in and req_x_in until
    // that edge. ssd_valid_in and best_valid_out are single-cycle pulses with no back-pressure.
    logic                 req_valid_in;
    logic [X_WIDTH-1:0]   req_x_in;
    logic                 req_ready_out;
    logic                 ssd_start_out;
    logic [X_WIDTH-1:0]   ssd_x_out;
    logic [DISP_W-1:0]    ssd_disp_out;
    logic                 ssd_valid_in;
    logic [SSD_WIDTH-1:0] ssd_value_in;
    logic                 best_valid_out;
    logic [DISP_W-1:0]    best_disp_out;
    logic [SSD_WIDTH-1:0] best_ssd_out;
    logic                 timeout_out;
    logic                 busy_out;
    logic [1:0]           state_dbg;

    modport slave (
        input  req_valid_in, req_x_in, ssd_valid_in, ssd_value_in,
        output req_ready_out, ssd_start_out, ssd_x_out, ssd_disp_out,
               best_valid_out, best_disp_out, best_ssd_out, timeout_out, busy_out, state_dbg
    );

    modport master (
        output req_valid_in, req_x_in, ssd_valid_in, ssd_value_in,
        input  req_ready_out, ssd_start_out, ssd_x_out, ssd_disp_out,
               best_valid_out, best_disp_out, best_ssd_out, timeout_out, busy_out, state_dbg
    );
endinterface

// File: rtl/ssd_disparity_scheduler.sv
// Walks the disparity range for one window, issuing one SSD job at a time and keeping the
// smallest result; a watchdog aborts the search if the datapath stops answering.
module ssd_disparity_scheduler #(
    parameter int MAX_DISP       = 16,
    parameter int SSD_WIDTH      = 24,
    parameter int X_WIDTH        = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    ssd_disparity_scheduler_if.slave   bus
);
    localparam int DISP_W = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [X_WIDTH-1:0] LAST_CLAMP = X_WIDTH'(MAX_DISP - 1);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [DISP_W-1:0]    disp;
    logic [DISP_W-1:0]    last_disp;
    logic                 best_seen;
    logic [SSD_WIDTH-1:0] min_ssd;
    logic [DISP_W-1:0]    min_disp;
    logic [WD_W-1:0]      watchdog;

    logic [DISP_W-1:0]    req_last;
    logic                 take;
    logic [SSD_WIDTH-1:0] cand_ssd;
    logic [DISP_W-1:0]    cand_disp;

    // Columns left of the image edge (x - d < 0) are never searched.
    assign req_last  = (bus.req_x_in > LAST_CLAMP) ? DISP_W'(MAX_DISP - 1) : DISP_W'(bus.req_x_in);
    // Strict compare: on a tie the earlier (lower) disparity keeps the win.
    assign take      = !best_seen || (bus.ssd_value_in < min_ssd);
    assign cand_ssd  = take ? bus.ssd_value_in : min_ssd;
    assign cand_disp = take ? disp : min_disp;

    assign bus.ssd_disp_out = disp;
    assign bus.state_dbg    = state;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            disp               <= '0;
            last_disp          <= '0;
            best_seen          <= 1'b0;
            min_ssd            <= '0;
            min_disp           <= '0;
            watchdog           <= '0;
            bus.req_ready_out  <= 1'b1;
            bus.ssd_start_out  <= 1'b0;
            bus.ssd_x_out      <= '0;
            bus.best_valid_out <= 1'b0;
            bus.best_disp_out  <= '0;
            bus.best_ssd_out   <= '0;
            bus.timeout_out    <= 1'b0;
            bus.busy_out       <= 1'b0;
        end else begin
            bus.ssd_start_out  <= 1'b0;
            bus.best_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid_in) begin
                        bus.ssd_x_out     <= bus.req_x_in;
                        disp              <= '0;
                        last_disp         <= req_last;
                        best_seen         <= 1'b0;
                        // All-ones / disparity 0 is what a search with no result reports.
                        min_ssd           <= '1;
                        min_disp          <= '0;
                        bus.ssd_start_out <= 1'b1;
                        bus.req_ready_out <= 1'b0;
                        bus.busy_out      <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.ssd_valid_in) begin
                        min_ssd   <= cand_ssd;
                        min_disp  <= cand_disp;
                        best_seen <= 1'b1;
                        if (disp == last_disp) begin
                            bus.best_valid_out <= 1'b1;
                            bus.best_disp_out  <= cand_disp;
                            bus.best_ssd_out   <= cand_ssd;
                            bus.timeout_out    <= 1'b0;
                            state              <= DONE;
                        end else begin
                            disp              <= disp + 1'b1;
                            bus.ssd_start_out <= 1'b1;
                            state             <= ISSUE;
                        end
                    end else if (watchdog == WD_LAST) begin
                        bus.best_valid_out <= 1'b1;
                        bus.best_disp_out  <= min_disp;
                        bus.best_ssd_out   <= min_ssd;
                        bus.timeout_out    <= 1'b1;
                        state              <= DONE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                DONE: begin
                    bus.req_ready_out <= 1'b1;
                    bus.busy_out      <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
